// File: rtl/timer_sequencer.sv
// Control FSM for a cascade of BCD down-counters forming an MM:SS timer.
// Drives the shared load strobe, per-digit borrow enables and a timed done alarm.
module timer_sequencer #(
  parameter int NDIG        = 4,
  parameter int TICK_DIV    = 50000000,
  parameter int ALARM_TICKS = 5
) (
  input  logic            clk,
  input  logic            clear,
  input  logic            start,
  input  logic            pause,
  input  logic            cancel,
  input  logic [NDIG-1:0] digit_zero,
  output logic            load_n,
  output logic [NDIG-1:0] digit_en,
  output logic            running,
  output logic            paused,
  output logic            done
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int AW = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS + 1) : 1;
  localparam logic [PW-1:0] PRESC_MAX  = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_TICKS - 1);
  localparam logic [AW-1:0] ALARM_ONE  = AW'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RUN    = 3'd2,
    S_PAUSED = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [AW-1:0]   alarm_q, alarm_d;
  logic            start_q, pause_q;

  logic            start_edge_s;
  logic            pause_edge_s;
  logic            all_zero_s;
  logic            presc_wrap_s;
  logic [PW-1:0]   presc_next_s;
  logic            run_tick_s;
  logic            chain_s;

  assign start_edge_s = start & ~start_q;
  assign pause_edge_s = pause & ~pause_q;
  assign all_zero_s   = &digit_zero;
  assign presc_wrap_s = (presc_q == PRESC_MAX);
  assign presc_next_s = presc_wrap_s ? {PW{1'b0}} : (presc_q + PRESC_ONE);

  // State, prescaler, alarm counter and input edge-detect registers
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q <= S_IDLE;
      presc_q <= {PW{1'b0}};
      alarm_q <= {AW{1'b0}};
      start_q <= 1'b0;
      pause_q <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      alarm_q <= alarm_d;
      start_q <= start;
      pause_q <= pause;
    end
  end

  // Next-state logic; cancel outranks every other request
  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    alarm_d    = alarm_q;
    run_tick_s = 1'b0;
    if (cancel) begin
      state_d = S_IDLE;
      presc_d = {PW{1'b0}};
      alarm_d = {AW{1'b0}};
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_edge_s) state_d = S_LOAD;
          else              state_d = S_IDLE;
        end
        S_LOAD: begin
          state_d = S_RUN;
          presc_d = {PW{1'b0}};
        end
        S_RUN: begin
          // Start is deliberately not consulted here: a restart mid-count is ignored.
          if (all_zero_s) begin
            state_d = S_DONE;
            presc_d = {PW{1'b0}};
            alarm_d = {AW{1'b0}};
          end else if (pause_edge_s) begin
            state_d = S_PAUSED;
          end else begin
            presc_d    = presc_next_s;
            run_tick_s = presc_wrap_s;
          end
        end
        S_PAUSED: begin
          if (start_edge_s || pause_edge_s) state_d = S_RUN;
          else                              state_d = S_PAUSED;
        end
        S_DONE: begin
          if (start_edge_s) begin
            state_d = S_LOAD;
            presc_d = {PW{1'b0}};
            alarm_d = {AW{1'b0}};
          end else begin
            presc_d = presc_next_s;
            if (presc_wrap_s) begin
              if (alarm_q == ALARM_LAST) begin
                state_d = S_IDLE;
                alarm_d = {AW{1'b0}};
              end else begin
                alarm_d = alarm_q + ALARM_ONE;
              end
            end else begin
              alarm_d = alarm_q;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          presc_d = {PW{1'b0}};
          alarm_d = {AW{1'b0}};
        end
      endcase
    end
  end

  // Borrow cascade: a digit decrements on a tick only when every lower digit is at zero
  always_comb begin
    digit_en = {NDIG{1'b0}};
    chain_s  = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      digit_en[i] = run_tick_s & chain_s;
      chain_s     = chain_s & digit_zero[i];
    end
  end

  assign load_n  = (state_q != S_LOAD);
  assign running = (state_q == S_RUN);
  assign paused  = (state_q == S_PAUSED);
  assign done    = (state_q == S_DONE);

endmodule
